lsu_split_aligner: RTL and testbench

Sequential load/store aligner between the M stage and the data memory port. It is the parametrised successor to the combinational data aligner. It accepts one byte/half/word/dword access per request and steers bytes into big-lane memory order, where byte offset 0 sits in the most-significant lane. It generates write strobes and sign/zero-extends load data. With splitting enabled, it breaks a misaligned access that crosses a memory-word boundary into two memory beats. It talks to the core and to memory through valid/ready handshakes.

---
 rtl/lsu_split_aligner_pkg.sv | 26 ++
 rtl/lsu_lane_steer.sv | 73 +++++++
 rtl/lsu_split_aligner.sv | 163 ++++++++++++++++
 tb/tb_lsu_split_aligner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_split_aligner_pkg.sv
// Shared constants for the LSU split aligner: size codes, FSM codes, lane order.
// Lane order: byte offset 0 lives in the most-significant memory lane.
package lsu_split_aligner_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic       wr;
    logic       se;
    logic [1:0] size;
    logic       err;
  } req_ctl_t;

  function automatic int lane_msb(input int xlen, input int k);
    return xlen - 1 - 8 * k;
  endfunction

endpackage

// File: rtl/lsu_lane_steer.sv
// Combinational byte steering: per-beat strobe/write lanes, read gather, extension.
// Beat 0 covers lanes from the offset up; beat 1 covers the wrapped low lanes.
module lsu_lane_steer
  import lsu_split_aligner_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OB = $clog2(NB)
) (
  input  logic [OB-1:0]   off,
  input  logic [1:0]      size,
  input  logic            beat,
  input  logic            wr,
  input  logic            se,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mdatai,
  input  logic [XLEN-1:0] acc,
  output logic [NB-1:0]   wstb,
  output logic [XLEN-1:0] wlanes,
  output logic [XLEN-1:0] rkeep,
  output logic [XLEN-1:0] rbytes,
  output logic [XLEN-1:0] rdata
);

  int len;

  // access length in bytes
  always_comb len = 1 << size;

  // map each memory lane to its data byte for the current beat
  always_comb begin
    int d;
    logic hit;
    logic [OB-1:0] ix;
    d = 0;
    hit = 1'b0;
    ix = '0;
    wstb = '0;
    wlanes = '0;
    rkeep = '0;
    rbytes = '0;
    for (int k = 0; k < NB; k++) begin
      d = k - int'(off);
      if (beat) hit = (d < 0) && (d + NB < len);
      else      hit = (d >= 0) && (d < len);
      ix = d[OB-1:0];
      if (hit) begin
        rkeep[8*ix +: 8] = 8'hff;
        rbytes[8*ix +: 8] = mdatai[lane_msb(XLEN, k) -: 8];
        if (wr) begin
          wstb[NB-1-k] = 1'b1;
          wlanes[lane_msb(XLEN, k) -: 8] = wdata[8*ix +: 8];
        end
      end
    end
  end

  // sign/zero-extend the assembled bytes from bit 8*len-1
  always_comb begin
    logic sb;
    unique case (size)
      SZ_B:    sb = acc[7];
      SZ_H:    sb = acc[15];
      SZ_W:    sb = acc[31];
      default: sb = acc[XLEN-1];
    endcase
    rdata = acc;
    for (int b = 0; b < XLEN; b++) begin
      if (b >= 8 * len) rdata[b] = se & sb;
    end
  end

endmodule

// File: rtl/lsu_split_aligner.sv
// Sequential load/store aligner between M stage and data memory.
// MISALIGN_SPLIT_EN: word-crossing accesses take two beats, else they error.
module lsu_split_aligner
  import lsu_split_aligner_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW = 32,
  localparam int NB = XLEN / 8,
  localparam int OB = $clog2(NB),
  localparam int MW = AW - OB
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [AW-1:0]   REQ_ADDR,
  input  logic [XLEN-1:0] REQ_WDATA,
  input  logic            REQ_WR,
  input  logic [1:0]      REQ_SIZE,
  input  logic            REQ_SE,
  output logic            RSP_VALID,
  output logic [XLEN-1:0] RSP_RDATA,
  output logic            RSP_ERR,
  output logic            MVALID,
  input  logic            MREADY,
  output logic [MW-1:0]   MADDR,
  output logic            MWE,
  output logic [NB-1:0]   MWSTB,
  output logic [XLEN-1:0] MDATAO,
  input  logic [XLEN-1:0] MDATAI
);

  logic [1:0]      state;
  req_ctl_t        ctl;
  logic [AW-1:0]   addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] acc;

  logic            req_illegal;
  logic            req_err;
  logic            beat;
  logic            in_beat;
  logic            is_resp;
  logic [NB-1:0]   wstb;
  logic [XLEN-1:0] wlanes;
  logic [XLEN-1:0] rkeep;
  logic [XLEN-1:0] rbytes;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] merged;

  // dword is only legal on a 64-bit datapath
  always_comb req_illegal = (REQ_SIZE == SZ_D) && (XLEN < 64);

`ifdef MISALIGN_SPLIT_EN
  logic split_q;

  // captured access crosses into the next memory word
  always_comb split_q = int'(addr[OB-1:0]) + (1 << ctl.size) > NB;

  // only an illegal size is fatal when splitting is available
  always_comb req_err = req_illegal;

  // second beat and any beat state
  always_comb begin
    beat = (state == ST_BEAT1);
    in_beat = (state == ST_BEAT0) || (state == ST_BEAT1);
  end
`else
  logic req_split;

  // incoming access would cross a memory word
  always_comb req_split = int'(REQ_ADDR[OB-1:0]) + (1 << REQ_SIZE) > NB;

  // crossing accesses are rejected without a memory beat
  always_comb req_err = req_illegal | req_split;

  // single-beat only
  always_comb begin
    beat = 1'b0;
    in_beat = (state == ST_BEAT0);
  end
`endif

  lsu_lane_steer #(.XLEN(XLEN)) u_steer (
    .off    (addr[OB-1:0]),
    .size   (ctl.size),
    .beat   (beat),
    .wr     (ctl.wr),
    .se     (ctl.se),
    .wdata  (wdata),
    .mdatai (MDATAI),
    .acc    (acc),
    .wstb   (wstb),
    .wlanes (wlanes),
    .rkeep  (rkeep),
    .rbytes (rbytes),
    .rdata  (rdata)
  );

  // fold this beat's read bytes into the assembly register
  always_comb merged = (acc & ~rkeep) | rbytes;

  // request capture and beat sequencing
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      ctl   <= '0;
      addr  <= '0;
      wdata <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            ctl.wr   <= REQ_WR;
            ctl.se   <= REQ_SE;
            ctl.size <= REQ_SIZE;
            ctl.err  <= req_err;
            addr     <= REQ_ADDR;
            wdata    <= REQ_WDATA;
            acc      <= '0;
            state    <= req_err ? ST_RESP : ST_BEAT0;
          end
        end
        ST_BEAT0: begin
          if (MREADY) begin
            acc <= merged;
`ifdef MISALIGN_SPLIT_EN
            state <= split_q ? ST_BEAT1 : ST_RESP;
`else
            state <= ST_RESP;
`endif
          end
        end
`ifdef MISALIGN_SPLIT_EN
        ST_BEAT1: begin
          if (MREADY) begin
            acc   <= merged;
            state <= ST_RESP;
          end
        end
`endif
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // handshake and memory-port outputs, all decoded from registered state
  always_comb begin
    is_resp   = (state == ST_RESP);
    REQ_READY = (state == ST_IDLE);
    MVALID    = in_beat;
    MADDR     = in_beat ? addr[AW-1:OB] + {{(MW-1){1'b0}}, beat} : '0;
    MWE       = in_beat & ctl.wr;
    MWSTB     = in_beat ? wstb : '0;
    MDATAO    = in_beat ? wlanes : '0;
    RSP_VALID = is_resp;
    RSP_ERR   = is_resp & ctl.err;
    RSP_RDATA = (is_resp && !ctl.wr && !ctl.err) ? rdata : '0;
  end

endmodule

// File: tb/tb_lsu_split_aligner.sv
// Directed bench for lsu_split_aligner (XLEN=32 and a small XLEN=64 instance).
// Expectations follow MISALIGN_SPLIT_EN when it is defined.
module tb_lsu_split_aligner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_wr, req_se;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mvalid, mready, mwe;
  logic [29:0] maddr;
  logic [3:0]  mwstb;
  logic [31:0] mdatao, mdatai;

  logic        w_req_valid, w_req_ready, w_req_wr, w_req_se;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata;
  logic [1:0]  w_req_size;
  logic        w_rsp_valid, w_rsp_err;
  logic [63:0] w_rsp_rdata;
  logic        w_mvalid, w_mready, w_mwe;
  logic [28:0] w_maddr;
  logic [7:0]  w_mwstb;
  logic [63:0] w_mdatao, w_mdatai;

  int vecs = 0;
  int miss = 0;

  lsu_split_aligner #(.XLEN(32), .AW(32)) dut (
    .CLK(clk), .RSTN(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .REQ_WR(req_wr), .REQ_SIZE(req_size), .REQ_SE(req_se),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .MVALID(mvalid), .MREADY(mready), .MADDR(maddr), .MWE(mwe),
    .MWSTB(mwstb), .MDATAO(mdatao), .MDATAI(mdatai)
  );

  lsu_split_aligner #(.XLEN(64), .AW(32)) dut64 (
    .CLK(clk), .RSTN(rst_n),
    .REQ_VALID(w_req_valid), .REQ_READY(w_req_ready),
    .REQ_ADDR(w_req_addr), .REQ_WDATA(w_req_wdata),
    .REQ_WR(w_req_wr), .REQ_SIZE(w_req_size), .REQ_SE(w_req_se),
    .RSP_VALID(w_rsp_valid), .RSP_RDATA(w_rsp_rdata), .RSP_ERR(w_rsp_err),
    .MVALID(w_mvalid), .MREADY(w_mready), .MADDR(w_maddr), .MWE(w_mwe),
    .MWSTB(w_mwstb), .MDATAO(w_mdatao), .MDATAI(w_mdatai)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic wr, input logic [1:0] sz, input logic se);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_wr    = wr;
    req_size  = sz;
    req_se    = se;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_addr = 0; req_wdata = 0;
    req_wr = 0; req_size = 0; req_se = 0;
    mready = 0; mdatai = 0;
    w_req_valid = 0; w_req_addr = 0; w_req_wdata = 0;
    w_req_wr = 0; w_req_size = 0; w_req_se = 0;
    w_mready = 0; w_mdatai = 0;
    step();
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_mvalid", mvalid, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_mwstb", mwstb, 0);
    rst_n = 1'b1;
    step();

    // word store, aligned
    mready = 1'b1;
    issue(32'h100, 32'h11223344, 1, 2'b10, 0);
    chk("t1_mvalid", mvalid, 1);
    chk("t1_maddr", maddr, 30'h40);
    chk("t1_mwe", mwe, 1);
    chk("t1_mwstb", mwstb, 4'b1111);
    chk("t1_mdatao", mdatao, 32'h44332211);
    chk("t1_early_rsp", rsp_valid, 0);
    step();
    chk("t1_rsp", rsp_valid, 1);
    chk("t1_err", rsp_err, 0);
    chk("t1_rdata", rsp_rdata, 0);
    chk("t1_mvalid_off", mvalid, 0);
    step();
    chk("t1_ready", req_ready, 1);
    chk("t1_rsp_pulse", rsp_valid, 0);

    // byte load, sign and zero extended
    mdatai = 32'h000000F0;
    issue(32'h103, 0, 0, 2'b00, 1);
    chk("t2_maddr", maddr, 30'h40);
    chk("t2_mwstb", mwstb, 0);
    chk("t2_mdatao", mdatao, 0);
    chk("t2_mwe", mwe, 0);
    step();
    chk("t2_se_rsp", rsp_valid, 1);
    chk("t2_se_rdata", rsp_rdata, 32'hFFFFFFF0);
    step();
    issue(32'h103, 0, 0, 2'b00, 0);
    step();
    chk("t2_ze_rdata", rsp_rdata, 32'h000000F0);
    step();

    // misaligned half load inside one word
    mdatai = 32'h00ABCD00;
    issue(32'h101, 0, 0, 2'b01, 1);
    chk("t2h_mvalid", mvalid, 1);
    step();
    chk("t2h_err", rsp_err, 0);
    chk("t2h_rdata", rsp_rdata, 32'hFFFFCDAB);
    step();

    // word load crossing a word boundary
    mdatai = 32'hAABBCCDD;
    issue(32'h102, 0, 0, 2'b10, 0);
`ifdef MISALIGN_SPLIT_EN
    chk("t3_b0_maddr", maddr, 30'h40);
    step();
    chk("t3_b1_mvalid", mvalid, 1);
    chk("t3_b1_maddr", maddr, 30'h41);
    chk("t3_b1_rsp", rsp_valid, 0);
    mdatai = 32'h11223344;
    step();
    chk("t3_rsp", rsp_valid, 1);
    chk("t3_rdata", rsp_rdata, 32'h2211DDCC);
`else
    chk("t3_rsp", rsp_valid, 1);
    chk("t3_err", rsp_err, 1);
    chk("t3_mvalid", mvalid, 0);
    chk("t3_rdata", rsp_rdata, 0);
`endif
    step();

    // half store crossing a word boundary
    issue(32'h0FF, 32'h0000BEEF, 1, 2'b01, 0);
`ifdef MISALIGN_SPLIT_EN
    chk("t4_b0_maddr", maddr, 30'h3F);
    chk("t4_b0_mwstb", mwstb, 4'b0001);
    chk("t4_b0_mdatao", mdatao, 32'h000000EF);
    step();
    chk("t4_b1_maddr", maddr, 30'h40);
    chk("t4_b1_mwstb", mwstb, 4'b1000);
    chk("t4_b1_mdatao", mdatao, 32'hBE000000);
    chk("t4_b1_mwe", mwe, 1);
    step();
    chk("t4_rsp", rsp_valid, 1);
    chk("t4_err", rsp_err, 0);
`else
    chk("t4_err", rsp_err, 1);
    chk("t4_mvalid", mvalid, 0);
`endif
    step();

    // MREADY low for five cycles in BEAT0
    mready = 1'b0;
    issue(32'h200, 32'hCAFEF00D, 1, 2'b10, 0);
    chk("t5_mvalid", mvalid, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_mvalid", mvalid, 1);
      chk("t5_hold_maddr", maddr, 30'h80);
      chk("t5_hold_mwstb", mwstb, 4'b1111);
      chk("t5_hold_mdatao", mdatao, 32'h0DF0FECA);
      chk("t5_hold_rsp", rsp_valid, 0);
    end
    mready = 1'b1;
    step();
    chk("t5_rsp", rsp_valid, 1);
    step();

    // reset pulse mid-access
`ifdef MISALIGN_SPLIT_EN
    issue(32'h103, 0, 0, 2'b10, 0);
    step();
    chk("t5r_in_beat1", maddr, 30'h41);
`else
    mready = 1'b0;
    issue(32'h300, 0, 0, 2'b10, 0);
`endif
    chk("t5r_pre_mvalid", mvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5r_mvalid_drop", mvalid, 0);
    chk("t5r_no_rsp", rsp_valid, 0);
    step();
    rst_n = 1'b1;
    mready = 1'b1;
    step();
    chk("t5r_ready", req_ready, 1);
    chk("t5r_rsp_after", rsp_valid, 0);
    chk("t5r_mvalid_after", mvalid, 0);

    // illegal dword at XLEN=32
    issue(32'h0, 0, 0, 2'b11, 0);
    chk("t6_rsp", rsp_valid, 1);
    chk("t6_err", rsp_err, 1);
    chk("t6_mvalid", mvalid, 0);
    step();
    chk("t6_ready", req_ready, 1);

    // dword load at XLEN=64
    w_mready = 1'b1;
    w_req_valid = 1'b1;
    w_req_addr = 32'h8;
    w_req_size = 2'b11;
    step();
    w_req_valid = 1'b0;
    chk("t6w_mvalid", w_mvalid, 1);
    chk("t6w_maddr", w_maddr, 29'h1);
    chk("t6w_mwstb", w_mwstb, 8'h00);
    w_mdatai = 64'h0102030405060708;
    step();
    chk("t6w_rsp", w_rsp_valid, 1);
    chk("t6w_err", w_rsp_err, 0);
    chk("t6w_rdata", w_rsp_rdata, 64'h0807060504030201);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
